// File: rtl/pocket_i2s_pkg.sv
// Shared constants and types for the pocket_i2s_tx codec transmitter.
// Defines the frame/slot geometry and the stereo pair type.
package pocket_i2s_pkg;

    localparam int FRAME_LEN     = 1024;
    localparam int DIV_W         = $clog2(FRAME_LEN);
    localparam int SLOT_W        = 16;
    localparam int SLOT_LSB      = $clog2(SLOT_W);
    localparam int LEFT_OFF      = 1;
    localparam int RIGHT_OFF     = 33;
    localparam int SAMPLE_W_DFLT = 16;

    typedef struct packed {
        logic [SAMPLE_W_DFLT-1:0] l;
        logic [SAMPLE_W_DFLT-1:0] r;
    } stereo_sample_t;

    // Lays both samples into a 64-slot frame image; bit 63 is slot 0.
    function automatic logic [63:0] frame_image(input logic [31:0] l,
                                                input logic [31:0] r,
                                                input int          w);
        logic [31:0] l_half;
        logic [31:0] r_half;
        l_half = l << (32 - LEFT_OFF - w);
        r_half = r << (64 - RIGHT_OFF - w);
        return {l_half, r_half};
    endfunction

endpackage

// File: rtl/pocket_i2s_fifo.sv
// Synchronous power-of-two FIFO with flush; holds stereo pairs for pocket_i2s_tx.
// Push is ignored when full, pop is ignored when empty, flush wins over both.
module pocket_i2s_fifo
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // NOTE: storage has no reset; the occupancy count alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pocket_i2s_tx.sv
// Stereo I2S transmitter: lock synchroniser, clk/1024 frame divider, FIFO load and serialiser.
// Optional macro I2S_TX_HOLD_LAST_EN repeats the previous pair on underrun instead of silence.
module pocket_i2s_tx
    import pocket_i2s_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int SAMPLE_W   = 16
) (
    input  logic                clk_audio,
    input  logic                reset_n,
    input  logic                pll_locked,
    input  logic [SAMPLE_W-1:0] sample_l,
    input  logic [SAMPLE_W-1:0] sample_r,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                i2s_mclk,
    output logic                i2s_sclk,
    output logic                i2s_lrck,
    output logic                i2s_dacdat,
    output logic                underrun
);
    localparam int PAIR_W = 2 * SAMPLE_W;
    localparam int SLOT_N = DIV_W - SLOT_LSB;

    logic [1:0]        lock_sync;
    logic              running;
    logic [DIV_W-1:0]  div_cnt;
    logic              frame_end;
    logic              push;
    logic              fifo_full;
    logic              fifo_empty;
    logic [PAIR_W-1:0] fifo_head;
    logic [PAIR_W-1:0] hold;
    logic [SLOT_N-1:0] slot_rev;
    logic [63:0]       frame_bits;
    logic              dat_next;

    always_ff @(posedge clk_audio or negedge reset_n) begin
        if (!reset_n) lock_sync <= '0;
        else          lock_sync <= {lock_sync[0], pll_locked};
    end

    assign running      = lock_sync[1];
    assign frame_end    = running && (div_cnt == DIV_W'(FRAME_LEN - 1));
    assign sample_ready = running && !fifo_full;
    assign push         = sample_valid && sample_ready;

    always_ff @(posedge clk_audio or negedge reset_n) begin
        if (!reset_n)      div_cnt <= '0;
        else if (!running) div_cnt <= '0;
        else               div_cnt <= div_cnt + 1'b1;
    end

    // Losing lock empties the queue so playback restarts cleanly on relock.
    pocket_i2s_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PAIR_W)
    ) u_fifo (
        .clk       (clk_audio),
        .rst_n     (reset_n),
        .flush     (!running),
        .push      (push),
        .push_data ({sample_l, sample_r}),
        .pop       (frame_end),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk_audio or negedge reset_n) begin
        if (!reset_n) begin
            hold <= '0;
        end else if (!running) begin
            hold <= '0;
        end else if (frame_end) begin
            if (!fifo_empty) hold <= fifo_head;
`ifdef I2S_TX_HOLD_LAST_EN
            else             hold <= hold;
`else
            else             hold <= '0;
`endif
        end
    end

    // The frame image is indexed by the inverted slot so slot 0 maps to bit 63.
    assign frame_bits = frame_image(32'(hold[PAIR_W-1:SAMPLE_W]), 32'(hold[SAMPLE_W-1:0]), SAMPLE_W);
    assign slot_rev   = ~div_cnt[DIV_W-1:SLOT_LSB];

    always_comb begin
        // NOTE: default assignment first so no path leaves dat_next unassigned and infers a latch.
        dat_next = 1'b0;
        if (running) dat_next = frame_bits[slot_rev];
    end

    always_ff @(posedge clk_audio or negedge reset_n) begin
        if (!reset_n) begin
            i2s_mclk   <= 1'b0;
            i2s_sclk   <= 1'b0;
            i2s_lrck   <= 1'b0;
            i2s_dacdat <= 1'b0;
            underrun   <= 1'b0;
        end else if (!running) begin
            i2s_mclk   <= 1'b0;
            i2s_sclk   <= 1'b0;
            i2s_lrck   <= 1'b0;
            i2s_dacdat <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            i2s_mclk   <= div_cnt[1];
            i2s_sclk   <= div_cnt[3];
            i2s_lrck   <= div_cnt[DIV_W-1];
            i2s_dacdat <= dat_next;
            underrun   <= frame_end && fifo_empty;
        end
    end

endmodule

// File: tb/tb_pocket_i2s_tx.sv
// Self-checking bench for pocket_i2s_tx: pin-level frame decoder against a pair scoreboard.
// Works in both builds; I2S_TX_HOLD_LAST_EN selects the underrun substitute expected.
module tb_pocket_i2s_tx;
    import pocket_i2s_pkg::*;

    localparam int HALF = 5;
    localparam int PER  = 2 * HALF;
`ifdef I2S_TX_HOLD_LAST_EN
    localparam bit HOLD_LAST = 1'b1;
`else
    localparam bit HOLD_LAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pll_locked;
    logic [15:0] sample_l;
    logic [15:0] sample_r;
    logic        sample_valid;
    logic        sample_ready;
    logic        i2s_mclk;
    logic        i2s_sclk;
    logic        i2s_lrck;
    logic        i2s_dacdat;
    logic        underrun;

    typedef struct {
        stereo_sample_t pair;
        longint         t;
    } sb_entry_t;

    sb_entry_t      exp_q[$];
    int             vectors = 0;
    int             miscompares = 0;
    bit             mon_en = 1'b0;
    int             rise_idx = 0;
    logic [63:0]    mon_bits = '0;
    logic [63:0]    last_frame = '0;
    stereo_sample_t cur = '0;
    bit             und_seen = 1'b0;
    int             und_count = 0;
    int             frames_done = 0;
    logic           prev_sclk = 1'b0;
    logic           prev_lrck = 1'b0;
    logic           prev_dat = 1'b0;
    logic           prev_und = 1'b0;

    pocket_i2s_tx #(
        .FIFO_DEPTH (4),
        .SAMPLE_W   (16)
    ) dut (
        .clk_audio    (clk),
        .reset_n      (reset_n),
        .pll_locked   (pll_locked),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .i2s_mclk     (i2s_mclk),
        .i2s_sclk     (i2s_sclk),
        .i2s_lrck     (i2s_lrck),
        .i2s_dacdat   (i2s_dacdat),
        .underrun     (underrun)
    );

    always #HALF clk = ~clk;

    function automatic logic [63:0] frame_exp(input stereo_sample_t c);
        return {1'b0, c.l, 15'b0, 1'b0, c.r, 15'b0};
    endfunction

    // Decodes pins each falling clk edge; each new frame pops the scoreboard
    // unless the head pair was accepted at or after the frame-load edge.
    task automatic monitor_loop();
        longint    boundary;
        bit        exp_und;
        int        slot;
        sb_entry_t e;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                rise_idx  = 0;
                mon_bits  = '0;
                cur       = '0;
                und_seen  = 1'b0;
                prev_sclk = i2s_sclk;
                prev_lrck = i2s_lrck;
                prev_dat  = i2s_dacdat;
                prev_und  = 1'b0;
            end else begin
                if (underrun) begin
                    und_count++;
                    und_seen = 1'b1;
                    if (prev_und) begin
                        miscompares++;
                        $display("FAIL underrun_width got two consecutive high cycles, expected one at %0t", $time);
                    end
                end
                if (i2s_dacdat !== prev_dat && !(prev_sclk && !i2s_sclk)) begin
                    miscompares++;
                    $display("FAIL dat_stability dacdat changed to %b without sclk fall at %0t", i2s_dacdat, $time);
                end
                if (i2s_lrck !== prev_lrck) begin
                    rise_idx = 0;
                    if (!i2s_lrck) begin
                        boundary = longint'($time) - 3 * HALF;
                        exp_und  = !(exp_q.size() > 0 && exp_q[0].t < boundary);
                        vectors++;
                        if (und_seen !== exp_und) begin
                            miscompares++;
                            $display("FAIL underrun_flag got %b expected %b at %0t", und_seen, exp_und, $time);
                        end
                        if (!exp_und) begin
                            e   = exp_q.pop_front();
                            cur = e.pair;
                        end else if (!HOLD_LAST) begin
                            cur = '0;
                        end
                        und_seen = 1'b0;
                    end
                end
                if (i2s_sclk && !prev_sclk) begin
                    slot = (i2s_lrck ? 32 : 0) + rise_idx;
                    mon_bits[63 - slot] = i2s_dacdat;
                    rise_idx++;
                    if (slot == 63) begin
                        vectors++;
                        if (mon_bits !== frame_exp(cur)) begin
                            miscompares++;
                            $display("FAIL frame_data got %h expected %h at %0t", mon_bits, frame_exp(cur), $time);
                        end
                        last_frame = mon_bits;
                        frames_done++;
                        mon_bits = '0;
                    end
                end
                prev_sclk = i2s_sclk;
                prev_lrck = i2s_lrck;
                prev_dat  = i2s_dacdat;
                prev_und  = underrun;
            end
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic push_pair(input logic [15:0] l, input logic [15:0] r);
        int        n;
        sb_entry_t e;
        sample_l     = l;
        sample_r     = r;
        sample_valid = 1'b1;
        n = 0;
        while (sample_ready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (sample_ready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL push_timeout sample_ready=%b expected 1", sample_ready);
        end else begin
            @(posedge clk);
            e.pair.l = l;
            e.pair.r = r;
            e.t      = longint'($time);
            exp_q.push_back(e);
        end
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic wait_lrck_fall();
        logic p;
        bit   found;
        p = i2s_lrck;
        found = 1'b0;
        for (int n = 0; n < 2100 && !found; n++) begin
            @(negedge clk);
            if (p && !i2s_lrck) found = 1'b1;
            p = i2s_lrck;
        end
        if (!found) begin
            vectors++;
            miscompares++;
            $display("FAIL lrck_fall_timeout no falling lrck within 2100 clks");
        end
    endtask

    task automatic wait_frames(input int n);
        int target;
        int budget;
        target = frames_done + n;
        budget = n * 1100;
        while (frames_done < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (frames_done < target) begin
            vectors++;
            miscompares++;
            $display("FAIL frame_timeout got %0d frames expected %0d", frames_done, target);
        end
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        pll_locked   = 1'b0;
        sample_valid = 1'b0;
        sample_l     = '0;
        sample_r     = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i % 25 == 24) begin
                vectors++;
                if ({sample_ready, i2s_mclk, i2s_sclk, i2s_lrck, i2s_dacdat, underrun} !== 6'b0) begin
                    miscompares++;
                    $display("FAIL reset_outputs got %b expected 000000",
                             {sample_ready, i2s_mclk, i2s_sclk, i2s_lrck, i2s_dacdat, underrun});
                end
            end
        end
        reset_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i % 25 == 24) begin
                vectors++;
                if ({sample_ready, i2s_mclk, i2s_sclk, i2s_lrck, i2s_dacdat, underrun} !== 6'b0) begin
                    miscompares++;
                    $display("FAIL unlocked_outputs got %b expected 000000",
                             {sample_ready, i2s_mclk, i2s_sclk, i2s_lrck, i2s_dacdat, underrun});
                end
            end
        end
    endtask

    task automatic test_lock();
        logic [3:0] exp_pins;
        int         d;
        longint     t1;
        longint     t2;
        bit         seen;
        logic       p;
        pll_locked = 1'b1;
        mon_en     = 1'b1;
        // Running two clks after lock; pins then show div_cnt from the previous clk.
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            d = k - 3;
            exp_pins[3] = (k >= 2);
            exp_pins[2] = (k >= 3) ? d[1] : 1'b0;
            exp_pins[1] = (k >= 3) ? d[3] : 1'b0;
            exp_pins[0] = 1'b0;
            vectors++;
            if ({sample_ready, i2s_mclk, i2s_sclk, i2s_lrck} !== exp_pins) begin
                miscompares++;
                $display("FAIL lock_startup clk %0d got ready/mclk/sclk/lrck=%b expected %b",
                         k, {sample_ready, i2s_mclk, i2s_sclk, i2s_lrck}, exp_pins);
            end
        end
        t1 = 0;
        t2 = 0;
        for (int r = 0; r < 2; r++) begin
            seen = 1'b0;
            p = i2s_lrck;
            for (int n = 0; n < 1100 && !seen; n++) begin
                @(negedge clk);
                if (!p && i2s_lrck) seen = 1'b1;
                p = i2s_lrck;
            end
            if (r == 0) t1 = longint'($time);
            else        t2 = longint'($time);
        end
        vectors++;
        if (t2 - t1 != longint'(1024 * PER)) begin
            miscompares++;
            $display("FAIL lrck_period got %0d time units expected %0d", t2 - t1, 1024 * PER);
        end
    endtask

    task automatic test_serial_format();
        wait_lrck_fall();
        push_pair(16'hA5C3, 16'h0001);
        wait_frames(2);
        vectors++;
        if (last_frame !== 64'h52E1_8000_0000_8000) begin
            miscompares++;
            $display("FAIL serial_format got %h expected 52e1800000008000", last_frame);
        end
    endtask

    task automatic test_full();
        logic [15:0] tab_l [5];
        logic [15:0] tab_r [5];
        int          n;
        tab_l = '{16'h1234, 16'h8000, 16'hFFFF, 16'h0F0F, 16'h5A5A};
        tab_r = '{16'hFEDC, 16'h7FFF, 16'h0000, 16'hF0F0, 16'hC3A5};
        wait_lrck_fall();
        for (int i = 0; i < 4; i++) push_pair(tab_l[i], tab_r[i]);
        vectors++;
        if (sample_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL full_ready got %b expected 0", sample_ready);
        end
        n = 0;
        while (sample_ready !== 1'b1 && n < 1100) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (sample_ready !== 1'b1 || i2s_lrck !== 1'b1) begin
            miscompares++;
            $display("FAIL full_release got ready=%b lrck=%b expected ready=1 lrck=1", sample_ready, i2s_lrck);
        end
        push_pair(tab_l[4], tab_r[4]);
        vectors++;
        if (i2s_lrck !== 1'b0) begin
            miscompares++;
            $display("FAIL full_release_edge got lrck=%b expected 0 one clk after frame load", i2s_lrck);
        end
        wait_frames(7);
    endtask

    task automatic test_underrun();
        int base;
        wait_lrck_fall();
        base = und_count;
        push_pair(16'h7E81, 16'h8001);
        wait_frames(4);
        vectors++;
        if (und_count - base != 2) begin
            miscompares++;
            $display("FAIL underrun_count got %0d expected 2", und_count - base);
        end
    endtask

    task automatic test_boundary_push();
        sb_entry_t e;
        stereo_sample_t want;
        wait_lrck_fall();
        repeat (1022) @(negedge clk);
        vectors++;
        if (sample_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL boundary_ready got %b expected 1", sample_ready);
        end
        sample_l     = 16'h3C96;
        sample_r     = 16'hA001;
        sample_valid = 1'b1;
        @(posedge clk);
        e.pair.l = 16'h3C96;
        e.pair.r = 16'hA001;
        e.t      = longint'($time);
        exp_q.push_back(e);
        @(negedge clk);
        sample_valid = 1'b0;
        vectors++;
        if (underrun !== 1'b1) begin
            miscompares++;
            $display("FAIL boundary_underrun got %b expected 1", underrun);
        end
        wait_frames(2);
        want.l = 16'h3C96;
        want.r = 16'hA001;
        vectors++;
        if (last_frame !== frame_exp(want)) begin
            miscompares++;
            $display("FAIL boundary_frame got %h expected %h", last_frame, frame_exp(want));
        end
    endtask

    task automatic test_lock_loss();
        int base;
        wait_lrck_fall();
        push_pair(16'h1111, 16'h2222);
        push_pair(16'h3333, 16'h4444);
        push_pair(16'h5555, 16'h6666);
        repeat (494) @(negedge clk);
        pll_locked = 1'b0;
        mon_en     = 1'b0;
        repeat (4) @(negedge clk);
        vectors++;
        if ({sample_ready, i2s_mclk, i2s_sclk, i2s_lrck, i2s_dacdat, underrun} !== 6'b0) begin
            miscompares++;
            $display("FAIL lockloss_outputs got %b expected 000000",
                     {sample_ready, i2s_mclk, i2s_sclk, i2s_lrck, i2s_dacdat, underrun});
        end
        exp_q.delete();
        repeat (20) @(negedge clk);
        base = und_count;
        pll_locked = 1'b1;
        mon_en     = 1'b1;
        wait_frames(3);
        vectors++;
        if (und_count - base != 2 || last_frame !== 64'h0) begin
            miscompares++;
            $display("FAIL relock_empty got underruns=%0d frame=%h expected 2 and 0", und_count - base, last_frame);
        end
    endtask

    initial begin
        fork
            monitor_loop();
            begin
                #(PER * 90000);
                $display("FAIL watchdog simulation did not finish within 90000 clks");
                $fatal(1, "watchdog expired");
            end
        join_none
        test_reset();
        test_lock();
        test_serial_format();
        test_full();
        test_underrun();
        test_boundary_push();
        test_lock_loss();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
